// File: rtl/decode_stage.sv
// Instruction decode stage: field decode, 16x16 register file with writeback
// bypass, and the ID/EX pipeline register with stall/flush control.
module decode_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       InstrD,
  input  logic [15:0]       PCD,
  input  logic [15:0]       PCPlus2D,
  input  logic              RegWriteW,
  input  logic [3:0]        RdW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              StallE,
  input  logic              FlushE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ImmExtE,
  output logic [15:0]       PCE,
  output logic [15:0]       PCPlus2E,
  output logic [3:0]        RdE,
  output logic [3:0]        Rs1E,
  output logic [3:0]        Rs2E,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              ALUSrcE,
  output logic              BranchE,
  output logic              JumpE,
  output logic              IllegalE,
  output logic [2:0]        ALUControlE
);

  function automatic logic signed [DATA_W-1:0] sext4(input logic [3:0] v);
    return {{(DATA_W-4){v[3]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext12(input logic [11:0] v);
    return {{(DATA_W-12){v[11]}}, v};
  endfunction

  logic [3:0] op, rd, rs1, rs2;
  assign op  = InstrD[15:12];
  assign rd  = InstrD[11:8];
  assign rs1 = InstrD[7:4];
  assign rs2 = InstrD[3:0];

  logic [DATA_W-1:0]        rf [16];
  logic [3:0]               ra2_p0;
  logic [DATA_W-1:0]        rd1_p0, rd2_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic                     regwrite_p0, memwrite_p0, resultsrc_p0, alusrc_p0;
  logic                     branch_p0, jump_p0, illegal_p0;
  logic [2:0]               aluctl_p0;

  always_comb begin
    regwrite_p0  = 1'b0;
    memwrite_p0  = 1'b0;
    resultsrc_p0 = 1'b0;
    alusrc_p0    = 1'b0;
    branch_p0    = 1'b0;
    jump_p0      = 1'b0;
    illegal_p0   = 1'b0;
    aluctl_p0    = 3'b000;
    imm_p0       = '0;
    ra2_p0       = rs2;
    case (op)
      4'h0: regwrite_p0 = 1'b1;
      4'h1: begin regwrite_p0 = 1'b1; aluctl_p0 = 3'b001; end
      4'h2: begin regwrite_p0 = 1'b1; aluctl_p0 = 3'b010; end
      4'h3: begin regwrite_p0 = 1'b1; aluctl_p0 = 3'b011; end
      4'h4: begin regwrite_p0 = 1'b1; alusrc_p0 = 1'b1; imm_p0 = sext4(rs2); end
      4'h5: begin
        regwrite_p0  = 1'b1;
        resultsrc_p0 = 1'b1;
        alusrc_p0    = 1'b1;
        imm_p0       = sext4(rs2);
      end
      // Stores and branches read rd as the second operand
      4'h6: begin memwrite_p0 = 1'b1; alusrc_p0 = 1'b1; imm_p0 = sext4(rs2); ra2_p0 = rd; end
      4'h8: begin
        branch_p0 = 1'b1;
        aluctl_p0 = 3'b001;
        imm_p0    = sext4(rs2) <<< 1;
        ra2_p0    = rd;
      end
      4'h9: begin jump_p0 = 1'b1; imm_p0 = sext12(InstrD[11:0]) <<< 1; end
      4'hF: ;
      default: illegal_p0 = 1'b1;
    endcase
  end

  // Register file: R0 never written; same-cycle writeback is bypassed to reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (RegWriteW && RdW != 4'd0) begin
      rf[RdW] <= ResultW;
    end
  end

  assign rd1_p0 = (rs1 == 4'd0) ? '0 :
                  (RegWriteW && RdW == rs1) ? ResultW : rf[rs1];
  assign rd2_p0 = (ra2_p0 == 4'd0) ? '0 :
                  (RegWriteW && RdW == ra2_p0) ? ResultW : rf[ra2_p0];

  // ---- ID/EX boundary: flush beats stall ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus2E    <= '0;
      RdE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      ALUSrcE     <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      IllegalE    <= 1'b0;
      ALUControlE <= 3'b000;
    end else if (!StallE) begin
      RD1E        <= rd1_p0;
      RD2E        <= rd2_p0;
      ImmExtE     <= imm_p0;
      PCE         <= PCD;
      PCPlus2E    <= PCPlus2D;
      RdE         <= rd;
      Rs1E        <= rs1;
      Rs2E        <= ra2_p0;
      RegWriteE   <= regwrite_p0;
      MemWriteE   <= memwrite_p0;
      ResultSrcE  <= resultsrc_p0;
      ALUSrcE     <= alusrc_p0;
      BranchE     <= branch_p0;
      JumpE       <= jump_p0;
      IllegalE    <= illegal_p0;
      ALUControlE <= aluctl_p0;
    end
  end

endmodule
